// File: rtl/div_qf_seq.sv
// Sequential restoring divider: {Q,F} = A*2^WF / B, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncate toward zero, saturating).
module div_qf_seq #(
   parameter int WA = 8,
   parameter int WB = 8,
   parameter int WF = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st,
   input  logic [WA-1:0] A,
   input  logic [WB-1:0] B,
   output logic [WA-1:0] Q,
   output logic [WF-1:0] F,
   output logic          busy,
   output logic          ok_div,
   output logic          dz
);

   localparam int N  = WA + WF;
   localparam int CW = $clog2(N) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [N-1:0]  sh;
   logic [WB-1:0] rem;
   logic [WB-1:0] dvs;
   logic [CW-1:0] cnt;
   logic          zpend;

   logic [WA-1:0] mag_a;
   logic [WB-1:0] mag_b;
   logic [WB:0]   trial;
   logic [WB:0]   diff;
   logic          ge;
   logic [WB-1:0] rem_nxt;
   logic [N-1:0]  q_nxt;
   logic [N-1:0]  res;
   logic          last;
   logic          take;

`ifdef DIV_SIGNED_EN
   logic neg;

   always_comb begin
      mag_a = A[WA-1] ? (~A + WA'(1)) : A;
      mag_b = B[WB-1] ? (~B + WB'(1)) : B;
   end

   // Only min/-1 can overflow a non-negative result; it clamps to the largest positive value.
   always_comb begin
      res = q_nxt;
      if (neg)
         res = ~q_nxt + N'(1);
      else if (q_nxt[N-1])
         res = {1'b0, {(N-1){1'b1}}};
   end
`else
   always_comb begin
      mag_a = A;
      mag_b = B;
      res   = q_nxt;
   end
`endif

   // The partial remainder stays below the divisor, so the shifted trial fits WB+1 bits.
   always_comb begin
      trial   = {rem, sh[N-1]};
      diff    = trial - {1'b0, dvs};
      ge      = ~diff[WB];
      rem_nxt = ge ? diff[WB-1:0] : trial[WB-1:0];
      q_nxt   = {sh[N-2:0], ge};
      last    = (state == RUN) && (cnt == CW'(N - 1));
      take    = st && ((state == IDLE) || last);
   end

   // A start is also taken on the final iteration edge so divisions run back to back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sh     <= '0;
         rem    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         zpend  <= 1'b0;
         Q      <= '0;
         F      <= '0;
         busy   <= 1'b0;
         ok_div <= 1'b0;
         dz     <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg    <= 1'b0;
`endif
      end else begin
         ok_div <= 1'b0;
         case (state)
            IDLE: begin
               if (zpend) begin
                  Q      <= '1;
                  F      <= '1;
                  dz     <= 1'b1;
                  ok_div <= 1'b1;
                  zpend  <= 1'b0;
               end
            end
            RUN: begin
               sh  <= q_nxt;
               rem <= rem_nxt;
               cnt <= cnt + CW'(1);
               if (last) begin
                  {Q, F} <= res;
                  ok_div <= 1'b1;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         if (take) begin
            if (B != '0) begin
               sh    <= {mag_a, {WF{1'b0}}};
               rem   <= '0;
               dvs   <= mag_b;
               cnt   <= '0;
               dz    <= 1'b0;
               state <= RUN;
               busy  <= 1'b1;
`ifdef DIV_SIGNED_EN
               neg   <= A[WA-1] ^ B[WB-1];
`endif
            end else begin
               zpend <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_qf_seq.sv
// Directed self-checking bench for div_qf_seq with WA=WB=WF=8.
// Signed vectors are used when DIV_SIGNED_EN is defined, their unsigned readings otherwise.
module tb_div_qf_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       st;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] Q;
   logic [7:0] F;
   logic       busy;
   logic       ok_div;
   logic       dz;

   int testsRun    = 0;
   int testsFailed = 0;
   int lat;
   int okSeen;

   div_qf_seq #(.WA(8), .WB(8), .WF(8)) dut (
      .clk(clk), .rst(rst), .st(st), .A(A), .B(B),
      .Q(Q), .F(F), .busy(busy), .ok_div(ok_div), .dz(dz)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse st for one edge with the given operands, then wait (bounded) for ok_div.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int latency);
      @(negedge clk);
      A  = a;
      B  = b;
      st = 1'b1;
      @(posedge clk);
      #1 st = 1'b0;
      latency = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (ok_div) begin
            latency = n;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      st  = 1'b0;
      A   = '0;
      B   = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset Q", Q, 0);
      checkOutput("reset F", F, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset ok_div", ok_div, 0);
      checkOutput("reset dz", dz, 0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(8'd7, 8'd2, lat);
      checkOutput("7/2 latency", lat, 16);
      checkOutput("7/2 Q", Q, 8'h03);
      checkOutput("7/2 F", F, 8'h80);
      checkOutput("7/2 dz", dz, 0);
      checkOutput("7/2 busy", busy, 0);
      @(posedge clk);
      #1 checkOutput("ok_div one cycle", ok_div, 0);

      applyStimulus(8'd1, 8'd3, lat);
      checkOutput("1/3 latency", lat, 16);
      checkOutput("1/3 Q", Q, 8'h00);
      checkOutput("1/3 F", F, 8'h55);
      applyStimulus(8'd255, 8'd1, lat);
      checkOutput("255/1 Q", Q, 8'hFF);
      checkOutput("255/1 F", F, 8'h00);

      applyStimulus(8'd9, 8'd0, lat);
      checkOutput("div0 latency", lat, 1);
      checkOutput("div0 dz", dz, 1);
      checkOutput("div0 Q", Q, 8'hFF);
      checkOutput("div0 F", F, 8'hFF);
      checkOutput("div0 busy", busy, 0);
      applyStimulus(8'd6, 8'd3, lat);
      checkOutput("6/3 dz cleared", dz, 0);
      checkOutput("6/3 Q", Q, 8'h02);
      checkOutput("6/3 F", F, 8'h00);

      // Restart during busy is ignored; st held through the completion edge starts the next one.
      @(negedge clk);
      A  = 8'd7;
      B  = 8'd2;
      st = 1'b1;
      @(posedge clk);
      #1 st = 1'b0;
      okSeen = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (n == 4) begin
            A  = 8'd100;
            B  = 8'd7;
            st = 1'b1;
         end
         if (n == 16) begin
            checkOutput("b2b first ok", ok_div, 1);
            checkOutput("b2b first Q", Q, 8'h03);
            checkOutput("b2b first F", F, 8'h80);
            checkOutput("b2b busy kept", busy, 1);
            st = 1'b0;
         end
         if (ok_div && n != 16) begin
            okSeen = n;
            break;
         end
      end
      checkOutput("b2b second latency", okSeen, 32);
      checkOutput("b2b second Q", Q, 8'h0E);
      checkOutput("b2b second F", F, 8'h49);

      // Reset mid-division aborts without a completion pulse.
      @(negedge clk);
      A  = 8'd7;
      B  = 8'd2;
      st = 1'b1;
      @(posedge clk);
      #1 st = 1'b0;
      okSeen = 0;
      for (int n = 1; n <= 24; n++) begin
         @(posedge clk);
         #1;
         if (ok_div) okSeen++;
         if (n == 7) rst = 1'b1;
         if (n == 8) begin
            checkOutput("abort busy", busy, 0);
            checkOutput("abort Q", Q, 0);
            checkOutput("abort F", F, 0);
            rst = 1'b0;
         end
      end
      checkOutput("abort no ok_div", okSeen, 0);

`ifdef DIV_SIGNED_EN
      applyStimulus(8'hF9, 8'h02, lat);
      checkOutput("-7/2 QF", {Q, F}, 16'hFC80);
      applyStimulus(8'h80, 8'hFF, lat);
      checkOutput("min/-1 Q", Q, 8'h7F);
      checkOutput("min/-1 F", F, 8'hFF);
      checkOutput("min/-1 latency", lat, 16);
`else
      applyStimulus(8'hF9, 8'h02, lat);
      checkOutput("249/2 QF", {Q, F}, 16'h7C80);
      applyStimulus(8'h80, 8'hFF, lat);
      checkOutput("128/255 Q", Q, 8'h00);
      checkOutput("128/255 F", F, 8'h80);
      checkOutput("128/255 latency", lat, 16);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/div_qf_seq.md
DIV_QF_SEQ -- requirements
Module: div_qf_seq

Interface
REQ-001 SHALL have parameter WA, default 8: dividend and integer-quotient width, 2..32.
REQ-002 SHALL have parameter WB, default 8: divisor width, 2..32.
REQ-003 SHALL have parameter WF, default 8: fractional-quotient width, 1..32.
REQ-004 SHALL have port clk  in  1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port st  in  1: start request, sampled each rising edge.
REQ-007 SHALL have port A  in  WA: dividend.
REQ-008 SHALL have port B  in  WB: divisor.
REQ-009 SHALL have port Q  out  WA: integer part of quotient, registered.
REQ-010 SHALL have port F  out  WF: fractional part of quotient, registered.
REQ-011 SHALL have port busy  out  1: division in progress.
REQ-012 SHALL have port ok_div  out  1: one-cycle completion pulse.
REQ-013 SHALL have port dz  out  1: divide-by-zero flag for the last division.

Function
REQ-014 SHALL compute {Q,F} = floor(A*2^WF / B), unsigned, as one restoring-division bit per clock, MSB first.
REQ-015 SHALL hold the partial remainder in WB+1 bits; no overflow is possible when B != 0.
REQ-016 SHALL use two states: IDLE (busy=0) and RUN (busy=1).
REQ-017 SHALL, in IDLE with st=1 and B != 0 at edge k, capture A and B, clear the iteration counter, and enter RUN (busy=1 from k+1).
REQ-018 SHALL, in RUN, perform exactly WA+WF iterations on edges k+1 .. k+WA+WF.
REQ-019 SHALL, on edge k+WA+WF, load Q/F with the result, assert ok_div for one cycle, and return to IDLE (busy=0).
REQ-020 SHALL, in IDLE with st=1 and B=0 at edge k, skip iteration and at edge k+1 set dz=1, Q=all ones, F=all ones, ok_div=1; busy stays 0.
REQ-021 SHALL clear dz on every accepted st with B != 0.
REQ-022 SHALL ignore st while busy=1; operands latched at start are not disturbed.
REQ-023 SHALL hold Q, F, dz unchanged between completions; inputs A and B may change freely after the start edge.
REQ-024 SHALL accept st in the same cycle that ok_div=1, giving back-to-back divisions with no dead cycle.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, set Q=0, F=0, busy=0, ok_div=0, dz=0 and the state to IDLE, and clear internal registers.
REQ-026 SHALL let rst override st and abort any division in progress, with no ok_div for the aborted operation.
REQ-027 SHALL give all registers the same values as reset at power-up.

Configuration
REQ-028 SHALL treat A, B and {Q,F} as two's complement when DIV_SIGNED_EN is defined: it divides magnitudes, negates {Q,F} when the operand signs differ, and truncates toward zero.
REQ-029 SHALL, with DIV_SIGNED_EN defined and A=-2^(WA-1), B=-1, saturate to Q=2^(WA-1)-1, F=all ones.
REQ-030 SHALL, with DIV_SIGNED_EN defined and B=0, give dz=1, Q=all ones, F=all ones.
REQ-031 SHALL, without DIV_SIGNED_EN, operate as unsigned only, with no sign logic synthesised; latency is identical in both modes.

Verification (WA=WB=WF=8)
REQ-032 SHALL verify: A=7, B=2, st pulse at edge k -> ok_div at k+16, Q=0x03, F=0x80, dz=0.
REQ-033 SHALL verify: A=1, B=3 -> Q=0x00, F=0x55; then A=255, B=1 -> Q=0xFF, F=0x00.
REQ-034 SHALL verify: B=0, st at edge k -> at k+1 dz=1, Q=0xFF, F=0xFF, ok_div=1, busy=0; next st with A=6, B=3 -> dz=0, Q=0x02, F=0x00.
REQ-035 SHALL verify: st re-asserted with new A/B at k+5 during a busy division -> ignored, original result delivered at k+16; st held high at k+16 -> second result at k+32.
REQ-036 SHALL verify: rst=1 at k+8 mid-division -> busy=0, Q=0, F=0 next cycle, and no ok_div appears at k+16.
REQ-037 SHALL verify, with DIV_SIGNED_EN defined: A=0xF9 (-7), B=0x02 -> {Q,F}=0xFC80; A=0x80, B=0xFF -> Q=0x7F, F=0xFF.
